// File: rtl/permutation_iterative_pkg.sv
// ascon_pack: shared types, FSM encodings and round constants for the
// iterative Ascon permutation engine and its single-round datapath.
package ascon_pack;

  typedef logic [63:0] type_word;

  // Word k of the packed array is Ascon word xk
  typedef type_word [4:0] type_state;

  // FSM encoding, kept as plain constants for compatibility with older tools
  typedef logic [1:0] type_perm_state;
  localparam type_perm_state ST_IDLE = 2'd0;
  localparam type_perm_state ST_LOAD = 2'd1;
  localparam type_perm_state ST_RUN  = 2'd2;
  localparam type_perm_state ST_DONE = 2'd3;

  // Round constant for round index idx: high nibble is the complement of the index
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {~idx, idx};
  endfunction

  // First diffusion rotation amount of word k
  function automatic int rot_a(input int k);
    case (k)
      0:       return 19;
      1:       return 61;
      2:       return 1;
      3:       return 10;
      default: return 7;
    endcase
  endfunction

  // Second diffusion rotation amount of word k
  function automatic int rot_b(input int k);
    case (k)
      0:       return 28;
      1:       return 39;
      2:       return 6;
      3:       return 17;
      default: return 41;
    endcase
  endfunction

endpackage

// File: rtl/permutation_iterative_if.sv
// permutation_iterative_if: start/done handshake and state buses between the
// upstream Ascon mode FSM (master) and the permutation engine (slave).
interface permutation_iterative_if;
  import ascon_pack::*;

  logic      start_i;
  logic      rounds12_i;
  type_state state_i;
  type_state state_o;
  logic      busy_o;
  logic      done_o;

  modport master (
    output start_i, rounds12_i, state_i,
    input  state_o, busy_o, done_o
  );

  modport slave (
    input  start_i, rounds12_i, state_i,
    output state_o, busy_o, done_o
  );

endinterface

// File: rtl/permutation_iterative_round_function.sv
// round_function: one combinational Ascon round - constant addition into the
// low byte of x2, bit-sliced 5-bit S-box, then the linear diffusion layer.
// linear_diffusion: the existing linear layer, xk ^= ror(xk,a) ^ ror(xk,b).
module linear_diffusion
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_word
      localparam int RA = rot_a(gi);
      localparam int RB = rot_b(gi);
      // Each word is mixed with two right-rotated copies of itself
      assign state_o[gi] = state_i[gi]
                         ^ {state_i[gi][RA-1:0], state_i[gi][63:RA]}
                         ^ {state_i[gi][RB-1:0], state_i[gi][63:RB]};
    end
  endgenerate

endmodule

module round_function
  import ascon_pack::*;
(
  input  type_state   state_i,
  input  logic [3:0]  round_i,
  output type_state   state_o
);

  type_state added;
  type_state mixed;
  type_state chi_out;
  type_state subst;

  // Constant addition touches only x2[7:0]
  always_comb begin
    added         = state_i;
    added[2][7:0] = state_i[2][7:0] ^ round_const(round_i);
  end

  // S-box input layer, bit-sliced across all 64 columns
  assign mixed[0] = added[0] ^ added[4];
  assign mixed[1] = added[1];
  assign mixed[2] = added[2] ^ added[1];
  assign mixed[3] = added[3];
  assign mixed[4] = added[4] ^ added[3];

  // Chi core: each word absorbs the AND of its two neighbours
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_chi
      assign chi_out[gi] = mixed[gi] ^ (~mixed[(gi + 1) % 5] & mixed[(gi + 2) % 5]);
    end
  endgenerate

  // S-box output layer
  assign subst[0] = chi_out[0] ^ chi_out[4];
  assign subst[1] = chi_out[1] ^ chi_out[0];
  assign subst[2] = ~chi_out[2];
  assign subst[3] = chi_out[3] ^ chi_out[2];
  assign subst[4] = chi_out[4];

  linear_diffusion u_diffusion (
    .state_i (subst),
    .state_o (state_o)
  );

endmodule

// File: rtl/permutation_iterative.sv
// permutation_iterative: iterative Ascon p^12 / p^6 engine with a start/done
// handshake. Owns the 320-bit state register and the 4-bit round index.
// Build option ASCON_UNROLL2_EN: two cascaded rounds per RUN cycle.
module permutation_iterative
  import ascon_pack::*;
(
  input  logic                     clock_i,
  input  logic                     resetb_i,
  permutation_iterative_if.slave   bus
);

  type_perm_state fsm_reg;
  logic [3:0]     round_reg;
  type_state      state_reg;
  type_state      round_out;

`ifdef ASCON_UNROLL2_EN
  localparam logic [3:0] ROUND_STEP = 4'd2;
  localparam logic [3:0] ROUND_LAST = 4'd10;

  type_state  round_mid;
  logic [3:0] round_second;

  assign round_second = round_reg + 4'd1;

  round_function u_round0 (
    .state_i (state_reg),
    .round_i (round_reg),
    .state_o (round_mid)
  );

  round_function u_round1 (
    .state_i (round_mid),
    .round_i (round_second),
    .state_o (round_out)
  );
`else
  localparam logic [3:0] ROUND_STEP = 4'd1;
  localparam logic [3:0] ROUND_LAST = 4'd11;

  round_function u_round0 (
    .state_i (state_reg),
    .round_i (round_reg),
    .state_o (round_out)
  );
`endif

  // Handshake FSM, round counter and state register; LOAD keeps the input
  // mux out of the round path for one cycle
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_reg   <= ST_IDLE;
      round_reg <= 4'd0;
      state_reg <= '0;
    end else begin
      case (fsm_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.start_i) begin
            state_reg <= bus.state_i;
            round_reg <= bus.rounds12_i ? 4'd0 : 4'd6;
            fsm_reg   <= ST_LOAD;
          end else begin
            fsm_reg   <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          fsm_reg <= ST_RUN;
        end
        ST_RUN: begin
          state_reg <= round_out;
          round_reg <= round_reg + ROUND_STEP;
          if (round_reg == ROUND_LAST) begin
            fsm_reg <= ST_DONE;
          end
        end
        default: begin
          fsm_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.state_o = state_reg;
  assign bus.busy_o  = (fsm_reg == ST_LOAD) || (fsm_reg == ST_RUN);
  assign bus.done_o  = (fsm_reg == ST_DONE);

endmodule

// File: tb/tb_permutation_iterative.sv
// tb_permutation_iterative: table-driven and randomized checks of the
// iterative Ascon permutation against a table-based reference round model.
module tb_permutation_iterative;
  import ascon_pack::*;

`ifdef ASCON_UNROLL2_EN
  localparam int RPC = 2;
`else
  localparam int RPC = 1;
`endif

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [0:11] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  localparam int RA [0:4] = '{19, 61, 1, 10, 7};
  localparam int RB [0:4] = '{28, 39, 6, 17, 41};

  logic clock;
  logic resetb;
  int   checks = 0;
  int   passes = 0;

  permutation_iterative_if bus ();

  permutation_iterative dut (
    .clock_i  (clock),
    .resetb_i (resetb),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit        r12;
    bit        poke;
    type_state din;
    type_state dout;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round from the algorithm description: table S-box per column
  function automatic type_state model_round(input type_state s_in, input int idx);
    type_state  s;
    type_state  t;
    logic [4:0] v;
    s = s_in;
    s[2][7:0] = s[2][7:0] ^ RC[idx];
    for (int b = 0; b < 64; b++) begin
      v = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
      for (int w = 0; w < 5; w++) t[w][b] = v[4 - w];
    end
    for (int w = 0; w < 5; w++) s[w] = t[w] ^ ror(t[w], RA[w]) ^ ror(t[w], RB[w]);
    return s;
  endfunction

  function automatic type_state model_perm(input type_state s_in, input int first, input int count);
    type_state s;
    s = s_in;
    for (int r = first; r < first + count; r++) s = model_round(s, r);
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts one permutation and follows it to done; cycle 0 is just after the start edge
  task automatic run_perm(input int id, input vec_t v);
    int cyc;
    int lat_exp;
    bit seen;
    lat_exp = (v.r12 ? 12 : 6) / RPC + 1;
    bus.start_i    = 1'b1;
    bus.rounds12_i = v.r12;
    bus.state_i    = v.din;
    tick();
    bus.start_i    = 1'b0;
    bus.rounds12_i = ~v.r12;
    bus.state_i    = rand_state();
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (bus.done_o) begin
        seen = 1'b1;
      end else begin
        chk_int("busy_high", longint'(bus.busy_o), 1);
        if (cyc == 0) chk("captured_state", bus.state_o, v.din);
        if (cyc == 2) chk("first_run_edge", bus.state_o, model_perm(v.din, v.r12 ? 0 : 6, RPC));
        bus.start_i = v.poke && (cyc == 1);
        tick();
        cyc++;
      end
    end
    bus.start_i = 1'b0;
    if (!seen) begin
      checks++;
      $display("FAIL done_timeout: got no done after %0d cycles, required %0d", cyc, lat_exp);
    end else begin
      chk_int("latency", cyc, lat_exp);
      chk("result", bus.state_o, v.dout);
    end
    $display("txn %0d rounds12=%0d poke=%0d latency=%0d x0=%h", id, v.r12, v.poke, cyc, bus.state_o[0]);
    tick();
    chk_int("done_single_pulse", longint'(bus.done_o), 0);
    chk_int("busy_after_done", longint'(bus.busy_o), 0);
    chk("state_held", bus.state_o, v.dout);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    type_state iv;
    type_state s6;
    type_state exp_bb;
    int        cyc;
    int        dones;

    iv = '0;
    iv[0] = 64'h80400C0600000000;
    s6 = '0;
    s6[0] = 64'h0123456789ABCDEF;

    vecs[0] = '{r12: 1'b1, poke: 1'b0, din: iv, dout: '0};
    vecs[1] = '{r12: 1'b0, poke: 1'b0, din: s6, dout: '0};
    vecs[2] = '{r12: 1'b1, poke: 1'b1, din: iv, dout: '0};
    for (int k = 3; k < 6; k++) begin
      vecs[k].r12  = 1'($urandom_range(0, 1));
      vecs[k].poke = 1'($urandom_range(0, 1));
      vecs[k].din  = rand_state();
    end
    for (int k = 0; k < 6; k++)
      vecs[k].dout = model_perm(vecs[k].din, vecs[k].r12 ? 0 : 6, vecs[k].r12 ? 12 : 6);

    // Reset state
    resetb         = 1'b0;
    bus.start_i    = 1'b0;
    bus.rounds12_i = 1'b0;
    bus.state_i    = '0;
    tick();
    tick();
    chk("reset_state", bus.state_o, '0);
    chk_int("reset_busy", longint'(bus.busy_o), 0);
    chk_int("reset_done", longint'(bus.done_o), 0);
    resetb = 1'b1;
    tick();

    // Table-driven vectors, including start pulses during RUN
    for (int k = 0; k < 6; k++) run_perm(k, vecs[k]);

    // start held high: done repeats with the full latency, no gap
    exp_bb         = vecs[0].dout;
    bus.start_i    = 1'b1;
    bus.rounds12_i = 1'b1;
    bus.state_i    = iv;
    tick();
    for (int p = 0; p < 3; p++) begin
      cyc = 0;
      while (!bus.done_o && cyc <= 40) begin
        tick();
        cyc++;
      end
      chk_int("b2b_latency", cyc, 12 / RPC + 1);
      chk("b2b_result", bus.state_o, exp_bb);
      $display("txn b2b%0d latency=%0d x0=%h", p, cyc, bus.state_o[0]);
      tick();
    end
    bus.start_i = 1'b0;
    chk_int("b2b_relaunch_busy", longint'(bus.busy_o), 1);
    for (int c = 0; c < 20; c++) tick();
    chk_int("b2b_drained_busy", longint'(bus.busy_o), 0);

    // Reset mid-run, with start also asserted across the reset edge
    bus.start_i    = 1'b1;
    bus.rounds12_i = 1'b1;
    bus.state_i    = iv;
    tick();
    bus.start_i = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    resetb      = 1'b0;
    bus.start_i = 1'b1;
    tick();
    chk("midrun_reset_state", bus.state_o, '0);
    chk_int("midrun_reset_busy", longint'(bus.busy_o), 0);
    chk_int("midrun_reset_done", longint'(bus.done_o), 0);
    bus.start_i = 1'b0;
    resetb      = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done_o) dones++;
    end
    chk_int("no_done_after_reset", dones, 0);
    $display("txn reset_midrun dones_after=%0d", dones);

    // Engine still works after the abort
    run_perm(6, vecs[1]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
